// File: rtl/i_decoder.sv
// RV32I instruction decoder for the ID stage: register selects, ALU op and control strobes, all registered.
// Optional I_DECODER_ILLEGAL_EN adds a registered 'illegal' flag for encodings that decode to a NOP.
module i_decoder #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] instr,
    output logic [3:0]           alu_op,
    output logic [REG_SEL-1:0]   rs1,
    output logic [REG_SEL-1:0]   rs2,
    output logic [REG_SEL-1:0]   rd,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write_out,
    output logic                 alu_src,
    output logic                 branch,
    output logic                 jump
`ifdef I_DECODER_ILLEGAL_EN
    ,
    output logic                 illegal
`endif
);

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned F7_W     = 7;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'b1010;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic [F3_W-1:0] F3_ADD = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL = 3'b001;
    localparam logic [F3_W-1:0] F3_SR  = 3'b101;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_SEL-1:0]  rs1;
        logic [REG_SEL-1:0]  rs2;
        logic [REG_SEL-1:0]  rd;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
        logic                alu_src;
        logic                branch;
        logic                jump;
    } dec_t;

    // funct3 -> ALU op shared by OP and OP-IMM; alt picks SUB/SRA.
    function automatic logic [ALU_OP_W-1:0] arith_op(input logic [F3_W-1:0] f3, input logic alt);
        logic [ALU_OP_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic             legal;
    logic             use_rs1;
    logic             use_rs2;
    logic             use_rd;
    logic             writes_rd;
    dec_t             dec_d;
    dec_t             dec_q;

    // Class decode, legality check, then field zeroing and x0 write suppression.
    always_comb begin
        opcode    = instr[6:0];
        funct3    = instr[14:12];
        funct7    = instr[31:25];
        legal     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        writes_rd = 1'b0;
        dec_d        = '0;
        dec_d.alu_op = ALU_ADD;

        case (opcode)
            OPC_OP: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                use_rd    = 1'b1;
                writes_rd = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec_d.alu_op = arith_op(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
                    dec_d.alu_op = arith_op(funct3, 1'b1);
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                use_rs1       = 1'b1;
                use_rd        = 1'b1;
                writes_rd     = 1'b1;
                dec_d.alu_src = 1'b1;
                dec_d.alu_op  = arith_op(funct3, (funct3 == F3_SR) && instr[30]);
                if (funct3 == F3_SLL) begin
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == F3_SR) begin
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end
            end
            OPC_LOAD: begin
                use_rs1          = 1'b1;
                use_rd           = 1'b1;
                writes_rd        = 1'b1;
                dec_d.alu_src    = 1'b1;
                dec_d.mem_read   = 1'b1;
                dec_d.mem_to_reg = 1'b1;
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec_d.alu_src   = 1'b1;
                dec_d.mem_write = 1'b1;
                legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec_d.alu_op = ALU_SUB;
                dec_d.branch = 1'b1;
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_JAL: begin
                use_rd     = 1'b1;
                writes_rd  = 1'b1;
                dec_d.jump = 1'b1;
            end
            OPC_JALR: begin
                use_rs1       = 1'b1;
                use_rd        = 1'b1;
                writes_rd     = 1'b1;
                dec_d.alu_src = 1'b1;
                dec_d.jump    = 1'b1;
                legal = (funct3 == F3_ADD);
            end
            OPC_LUI: begin
                use_rd        = 1'b1;
                writes_rd     = 1'b1;
                dec_d.alu_src = 1'b1;
                dec_d.alu_op  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                use_rd        = 1'b1;
                writes_rd     = 1'b1;
                dec_d.alu_src = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // Anything illegal collapses to an all-zero NOP.
        if (!legal) begin
            dec_d        = '0;
            dec_d.alu_op = ALU_ADD;
            use_rs1      = 1'b0;
            use_rs2      = 1'b0;
            use_rd       = 1'b0;
            writes_rd    = 1'b0;
        end

        dec_d.rs1       = use_rs1 ? REG_SEL'(instr[19:15]) : '0;
        dec_d.rs2       = use_rs2 ? REG_SEL'(instr[24:20]) : '0;
        dec_d.rd        = use_rd  ? REG_SEL'(instr[11:7])  : '0;
        dec_d.reg_write = writes_rd && (dec_d.rd != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

`ifdef I_DECODER_ILLEGAL_EN
    logic illegal_d;
    logic illegal_q;

    assign illegal_d = ~legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

    assign alu_op        = dec_q.alu_op;
    assign rs1           = dec_q.rs1;
    assign rs2           = dec_q.rs2;
    assign rd            = dec_q.rd;
    assign mem_read      = dec_q.mem_read;
    assign mem_write     = dec_q.mem_write;
    assign mem_to_reg    = dec_q.mem_to_reg;
    assign reg_write_out = dec_q.reg_write;
    assign alu_src       = dec_q.alu_src;
    assign branch        = dec_q.branch;
    assign jump          = dec_q.jump;

endmodule

// File: tb/tb_i_decoder.sv
// Scoreboard bench for i_decoder: directed vectors plus random instructions against a rule-level model.
module tb_i_decoder;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       illegal;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        exp_t        e;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [3:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic        mem_read, mem_write, mem_to_reg, reg_write_out, alu_src, branch, jump;
`ifdef I_DECODER_ILLEGAL_EN
    logic        illegal;
`endif

    int    total = 0;
    int    bad   = 0;
    item_t exp_q[$];
    exp_t  act;

    i_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .alu_op        (alu_op),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write_out (reg_write_out),
        .alu_src       (alu_src),
        .branch        (branch),
        .jump          (jump)
`ifdef I_DECODER_ILLEGAL_EN
        ,
        .illegal       (illegal)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        act            = '0;
        act.alu_op     = alu_op;
        act.rs1        = rs1;
        act.rs2        = rs2;
        act.rd         = rd;
        act.mem_read   = mem_read;
        act.mem_write  = mem_write;
        act.mem_to_reg = mem_to_reg;
        act.reg_write  = reg_write_out;
        act.alu_src    = alu_src;
        act.branch     = branch;
        act.jump       = jump;
`ifdef I_DECODER_ILLEGAL_EN
        act.illegal    = illegal;
`endif
    end

    function automatic exp_t mk(input int alu, input int r1, input int r2, input int d,
                                input bit mr, input bit mw, input bit m2r, input bit rw,
                                input bit src, input bit br, input bit j, input bit ill);
        exp_t e;
        e.alu_op = 4'(alu);  e.rs1 = 5'(r1);  e.rs2 = 5'(r2);  e.rd = 5'(d);
        e.mem_read = mr;  e.mem_write = mw;  e.mem_to_reg = m2r;  e.reg_write = rw;
        e.alu_src = src;  e.branch = br;  e.jump = j;  e.illegal = ill;
        return e;
    endfunction

    // Reference: RV32I decode rules expressed directly from the instruction classes.
    function automatic exp_t model(input logic [31:0] x);
        logic [6:0] opc = x[6:0];
        logic [2:0] f3  = x[14:12];
        logic [6:0] f7  = x[31:25];
        logic [3:0] op_by_f3 [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        bit   ok = 1, wr = 0, k1 = 0, k2 = 0, kd = 0;
        exp_t e = '0;
        case (opc)
            7'b0110011: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.alu_op = op_by_f3[f3] + 4'(f7 == 7'h20);
                k1 = 1; k2 = 1; kd = 1; wr = 1;
            end
            7'b0010011: begin
                if (f3 == 3'd1)      ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                e.alu_op = op_by_f3[f3] + 4'(f3 == 3'd5 && x[30]);
                e.alu_src = 1; k1 = 1; kd = 1; wr = 1;
            end
            7'b0000011: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; k1 = 1; kd = 1; wr = 1;
            end
            7'b0100011: begin
                ok = (f3 <= 3'd2);
                e.alu_src = 1; e.mem_write = 1; k1 = 1; k2 = 1;
            end
            7'b1100011: begin
                ok = !(f3 inside {3'd2, 3'd3});
                e.alu_op = 4'd1; e.branch = 1; k1 = 1; k2 = 1;
            end
            7'b1101111: begin e.jump = 1; kd = 1; wr = 1; end
            7'b1100111: begin
                ok = (f3 == 3'd0);
                e.alu_src = 1; e.jump = 1; k1 = 1; kd = 1; wr = 1;
            end
            7'b0110111: begin e.alu_op = 4'd10; e.alu_src = 1; kd = 1; wr = 1; end
            7'b0010111: begin e.alu_src = 1; kd = 1; wr = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.illegal = 1'b1;
            return e;
        end
        e.rs1 = k1 ? x[19:15] : 5'd0;
        e.rs2 = k2 ? x[24:20] : 5'd0;
        e.rd  = kd ? x[11:7]  : 5'd0;
        e.reg_write = wr && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        logic [31:0] x = $urandom;
        int          k = $urandom_range(0, 10);
        if (k < 9) x[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0, 1:    x[31:25] = 7'h00;
            2:       x[31:25] = 7'h20;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) x[14:12] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
        if ($urandom_range(0, 7) == 0) x[11:7] = 5'd0;
        return x;
    endfunction

    // Called on a falling edge: present the instruction and queue its expected decode.
    task automatic drive(input logic [31:0] x, input exp_t e);
        item_t it;
        instr = x;
        it.instr = x;
        it.e = e;
        exp_q.push_back(it);
        @(negedge clk);
    endtask

    task automatic check_now(input string name, input exp_t e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d decodes never observed, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: each registered decode is compared one cycle after its instruction was applied.
    initial begin
        item_t it;
        exp_t  e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && exp_q.size() > 0) begin
                it = exp_q.pop_front();
                e  = it.e;
`ifndef I_DECODER_ILLEGAL_EN
                e.illegal = 1'b0;
`endif
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL decode instr=%h: got=%h expected=%h", it.instr, act, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] x;
        rst_n = 1'b0;
        instr = 32'h00ee8c33;
        repeat (2) @(negedge clk);
        check_now("reset_state", '0);

        rst_n = 1'b1;
        drive(32'h00ee8c33, mk(0, 29, 14, 24, 0, 0, 0, 1, 0, 0, 0, 0));
        drive(32'h400bd633, mk(7, 23, 0, 12, 0, 0, 0, 1, 0, 0, 0, 0));
        drive(32'h00eb9013, mk(2, 23, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        drive(32'h00812283, mk(0, 2, 0, 5, 1, 0, 1, 1, 1, 0, 0, 0));
        drive(32'h00512423, mk(0, 2, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        drive(32'h00208463, mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(32'h008000ef, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        drive(32'h123451b7, mk(10, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0));
        drive(32'hffffffff, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drive(32'h42ee8c33, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < 400; i++) begin
            x = rand_instr();
            drive(x, model(x));
        end

        // Asynchronous reset between edges while a live decode is held.
        drive(32'h00ee8c33, mk(0, 29, 14, 24, 0, 0, 0, 1, 0, 0, 0, 0));
        drain();
        rst_n = 1'b0;
        #1;
        check_now("async_reset_clear", '0);
        @(posedge clk);
        #1;
        check_now("reset_held_over_edge", '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h00812283, mk(0, 2, 0, 5, 1, 0, 1, 1, 1, 0, 0, 0));
        drive(32'h008000ef, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
